fc_120_ctrl: RTL and testbench
==============================

# fc_120_ctrl

Sequencer for the 120-input fully-connected datapath in the LeNet-5 classifier stage. On a start pulse it walks neuron indices 0..NUM_NEURONS-1 and, for each neuron, does four things:
- reads that neuron's weight row and bias from the weight/bias memory;
- waits out the memory read latency;
- samples the datapath's combinational sum, with optional ReLU;
- presents the result on a valid/ready stream to the next layer.

The 120-element activation vector is held stable by the upstream layer for the whole pass and does not pass through this block.

## Interface
- BIT_WIDTH, 32: weight/bias width of the datapath (informational; not used internally).
- OUT_WIDTH, 64: width of the datapath sum and of res_data.
- NUM_NEURONS, 84: neurons per pass; legal range 1..2^ADDR_WIDTH.
- ADDR_WIDTH, 7: width of w_addr and res_idx.
- RD_LAT, 1: weight/bias memory read latency in cycles; legal range ≥1.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a pass; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until the final result handshake.
- done  out  1  one-cycle pulse, in the cycle after the final handshake.
- w_rd_en  out  1  memory read strobe; high only in FETCH.
- w_addr  out  ADDR_WIDTH  neuron index for the weight row and bias; registered.
- fc_sum  in  OUT_WIDTH  signed datapath sum; valid RD_LAT cycles after w_rd_en.
- res_data  out  OUT_WIDTH  signed result, after ReLU when enabled.
- res_idx  out  ADDR_WIDTH  neuron index of res_data.
- res_valid  out  1  result-available flag.
- res_ready  in  1  downstream accept.

## Operation
FSM states are IDLE, FETCH, WAIT, OUT.

- **IDLE**
  - start=1 moves to FETCH and sets the neuron counter n=0.
- **FETCH** (exactly one cycle)
  - Drives w_rd_en=1 and w_addr=n.
  - Loads the wait counter with RD_LAT-1, then moves to WAIT.
- **WAIT** (RD_LAT cycles)
  - The counter decrements each cycle.
  - On the cycle the counter reads 0, the block registers fc_sum (after ReLU when enabled) into res_data, registers n into res_idx, and moves to OUT.
- **OUT**
  - res_valid=1.
  - On res_valid&res_ready with n<NUM_NEURONS-1: n increments and the FSM moves to FETCH.
  - On res_valid&res_ready with n=NUM_NEURONS-1: the FSM moves to IDLE, busy falls, and done pulses in the next cycle.

Arithmetic and widths:
- fc_sum is treated as two's complement.
- The ReLU test uses bit OUT_WIDTH-1.
- No truncation or extension: res_data is exactly OUT_WIDTH bits.

Boundary conditions:
- start while busy is ignored. This includes start in OUT on the final handshake cycle.
- start in the done-pulse cycle (state IDLE) is accepted.
- NUM_NEURONS=1: a single FETCH/WAIT/OUT sequence, then done.
- rst_n low at any point, including mid-pass, returns the block to IDLE asynchronously and clears every output. The partial pass is discarded, and the next start begins at n=0.

## Timing
- Reset values: busy, done, w_rd_en, res_valid = 0; w_addr, res_idx, res_data = 0.
- With start sampled at edge E, FETCH occupies cycle E+1 and res_valid first rises in cycle E+2+RD_LAT.
- With res_ready held high, one result is produced every RD_LAT+2 cycles.
- While res_valid=1 and res_ready=0:
  - res_data and res_idx are held stable;
  - w_rd_en stays 0;
  - no further memory read is issued.
- w_addr holds its last value outside FETCH.
- res_valid never deasserts without a handshake, except on reset.

## Configuration
- FC_RELU_EN defined: a negative fc_sum is captured as 0; a non-negative one is captured unchanged.
- FC_RELU_EN undefined: fc_sum is captured unchanged (linear output, for the final logits layer).

## Test plan
- **Reset:** assert rst_n=0 mid-cycle with all inputs random → every output is 0 immediately; FSM is in IDLE.
- **Nominal pass:** NUM_NEURONS=84, RD_LAT=1, res_ready=1, start at edge 0, fc_sum = 1000+w_addr driven one cycle after FETCH. Required response:
  - res_valid in cycles 3, 6, …, 252;
  - res_idx 0..83;
  - res_data 1000..1083;
  - done in cycle 253 only.
- **Backpressure:** hold res_ready=0 for 5 cycles while res_idx=10 → res_data/res_idx stable, w_rd_en=0 throughout; FETCH with w_addr=11 occurs the cycle after res_ready rises.
- **ReLU:** fc_sum=-5 → res_data=0 with FC_RELU_EN and -5 without; fc_sum=+7 → 7 in both builds.
- **Latency:** RD_LAT=3, fc_sum = 0xDEAD except 42 in cycle F+3 → res_data=42; per-result period is 5 cycles.
- **Abort/ignore:** start pulses at n=20 cause no effect; rst_n pulse at n=40 clears outputs; a following start yields res_idx=0 first and done only after 84 results.

Source files
------------

// File: rtl/fc_120_ctrl_if.sv
// rtl/fc_120_ctrl_if.sv - weight-memory and result-stream bundle for fc_120_ctrl
//
// Signals:
//   w_rd_en    master->slave  weight/bias memory read strobe
//   w_addr     master->slave  neuron index for weight row and bias
//   fc_sum     slave->master  signed datapath sum, RD_LAT cycles after w_rd_en
//   res_data   master->slave  signed result (after optional ReLU)
//   res_idx    master->slave  neuron index of res_data
//   res_valid  master->slave  result-available flag
//   res_ready  slave->master  downstream accept
interface fc_120_ctrl_if #(
    parameter int OUT_WIDTH  = 64,
    parameter int ADDR_WIDTH = 7
);
    logic                  w_rd_en;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [OUT_WIDTH-1:0]  fc_sum;
    logic [OUT_WIDTH-1:0]  res_data;
    logic [ADDR_WIDTH-1:0] res_idx;
    logic                  res_valid;
    logic                  res_ready;

    modport master (
        output w_rd_en, w_addr, res_data, res_idx, res_valid,
        input  fc_sum, res_ready
    );

    modport slave (
        input  w_rd_en, w_addr, res_data, res_idx, res_valid,
        output fc_sum, res_ready
    );
endinterface

// File: rtl/fc_120_ctrl.sv
// rtl/fc_120_ctrl.sv - neuron sequencer for the 120-input fully-connected layer
//
// Walks neuron indices 0..NUM_NEURONS-1 on a start pulse: fetch weights/bias,
// wait out the memory latency, capture the datapath sum, hand it downstream.
//
// Optional feature macro: FC_RELU_EN (defined: negative sums captured as 0).
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   single-cycle pass request, honoured only in IDLE
//   busy   out  high while a pass is in progress
//   done   out  one-cycle pulse after the final result handshake
//   bus    master modport of fc_120_ctrl_if (memory read + result stream)
module fc_120_ctrl #(
    parameter int BIT_WIDTH   = 32,
    parameter int OUT_WIDTH   = 64,
    parameter int NUM_NEURONS = 84,
    parameter int ADDR_WIDTH  = 7,
    parameter int RD_LAT      = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    fc_120_ctrl_if.master bus
);
    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_N = ADDR_WIDTH'(NUM_NEURONS - 1);

    generate
        if (BIT_WIDTH < 1 || RD_LAT < 1 || NUM_NEURONS < 1 ||
            NUM_NEURONS > (1 << ADDR_WIDTH)) begin : g_bad_params
            $error("fc_120_ctrl: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_OUT
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] n;
    logic [CW-1:0]         cnt;
    logic [OUT_WIDTH-1:0]  sum_act;

    always_comb begin
        sum_act = bus.fc_sum;
`ifdef FC_RELU_EN
        if (bus.fc_sum[OUT_WIDTH-1]) begin
            sum_act = '0;
        end
`endif
    end

    // w_rd_en and w_addr are set on the edge that enters FETCH so they are
    // registered outputs aligned exactly with the FETCH cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            n             <= '0;
            cnt           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            bus.w_rd_en   <= 1'b0;
            bus.w_addr    <= '0;
            bus.res_data  <= '0;
            bus.res_idx   <= '0;
            bus.res_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_FETCH;
                        n           <= '0;
                        bus.w_addr  <= '0;
                        bus.w_rd_en <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                S_FETCH: begin
                    bus.w_rd_en <= 1'b0;
                    cnt         <= CW'(RD_LAT - 1);
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        bus.res_data  <= sum_act;
                        bus.res_idx   <= n;
                        bus.res_valid <= 1'b1;
                        state         <= S_OUT;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_OUT: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        if (n == LAST_N) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            n           <= n + ADDR_WIDTH'(1);
                            bus.w_addr  <= n + ADDR_WIDTH'(1);
                            bus.w_rd_en <= 1'b1;
                            state       <= S_FETCH;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_120_ctrl.sv
// tb/tb_fc_120_ctrl.sv - directed-vector bench for fc_120_ctrl
module tb_fc_120_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic start3;
    logic busy, done, busy3, done3;
    logic ready;
    logic ovr_en;
    logic [63:0] ovr_val;
    logic [63:0] fc3;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fc_120_ctrl_if #(.OUT_WIDTH(64), .ADDR_WIDTH(7)) bus ();
    fc_120_ctrl_if #(.OUT_WIDTH(64), .ADDR_WIDTH(7)) bus3 ();

    assign bus.fc_sum     = ovr_en ? ovr_val : 64'd1000 + 64'(bus.w_addr);
    assign bus.res_ready  = ready;
    assign bus3.fc_sum    = fc3;
    assign bus3.res_ready = 1'b1;

    fc_120_ctrl #(
        .BIT_WIDTH(32), .OUT_WIDTH(64), .NUM_NEURONS(84), .ADDR_WIDTH(7), .RD_LAT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .bus(bus)
    );

    fc_120_ctrl #(
        .BIT_WIDTH(32), .OUT_WIDTH(64), .NUM_NEURONS(2), .ADDR_WIDTH(7), .RD_LAT(3)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .done(done3), .bus(bus3)
    );

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        check_vec({tag, "_busy"},  busy, 0);
        check_vec({tag, "_done"},  done, 0);
        check_vec({tag, "_rd_en"}, bus.w_rd_en, 0);
        check_vec({tag, "_valid"}, bus.res_valid, 0);
        check_vec({tag, "_addr"},  bus.w_addr, 0);
        check_vec({tag, "_idx"},   bus.res_idx, 0);
        check_vec({tag, "_data"},  bus.res_data, 0);
    endtask

    // Advance to the next cycle holding a valid result (bounded), then check it.
    task automatic next_result(input int idx, input logic [63:0] data);
        int i;
        i = 0;
        @(negedge clk);
        while (!bus.res_valid && i < 20) begin
            @(negedge clk);
            i++;
        end
        check_vec("res_valid", bus.res_valid, 1);
        check_vec("res_idx", bus.res_idx, 64'(idx));
        check_vec("res_data", bus.res_data, data);
        check_vec("done_mid", done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] relu_neg;
        logic        exp_v;
`ifdef FC_RELU_EN
        relu_neg = 64'd0;
`else
        relu_neg = 64'hFFFF_FFFF_FFFF_FFFB;
`endif
        rst_n   = 1'b0;
        start   = 1'(($urandom));
        start3  = 1'(($urandom));
        ready   = 1'(($urandom));
        ovr_en  = 1'b0;
        ovr_val = 64'd0;
        fc3     = 64'hDEAD;

        // Reset asserted before any clock edge: outputs must already be zero.
        #3;
        check_reset("rst0");
        check_vec("rst0_busy3", busy3, 0);
        @(negedge clk);
        start  = 1'b0;
        start3 = 1'b0;
        ready  = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Nominal pass: start sampled at edge 0, cycle c lies between edges c-1 and c.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 256; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            exp_v = (c % 3 == 0) && (c <= 252);
            check_vec("nom_valid", bus.res_valid, 64'(exp_v));
            if (exp_v) begin
                check_vec("nom_idx", bus.res_idx, 64'(c / 3 - 1));
                check_vec("nom_data", bus.res_data, 64'(1000 + c / 3 - 1));
            end
            check_vec("nom_done", done, 64'(c == 253));
            check_vec("nom_busy", busy, 64'(c <= 252));
            check_vec("nom_rd_en", bus.w_rd_en, 64'((c % 3 == 1) && (c <= 250)));
        end

        // Backpressure, ignored start and mid-pass reset.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_vec("p2_fetch0", bus.w_rd_en, 1);
        for (int k = 0; k <= 10; k++) next_result(k, 64'(1000 + k));
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_vec("bp_valid", bus.res_valid, 1);
            check_vec("bp_idx", bus.res_idx, 10);
            check_vec("bp_data", bus.res_data, 1010);
            check_vec("bp_rd_en", bus.w_rd_en, 0);
        end
        ready = 1'b1;
        @(negedge clk);
        check_vec("bp_fetch", bus.w_rd_en, 1);
        check_vec("bp_addr", bus.w_addr, 11);
        for (int k = 11; k <= 20; k++) next_result(k, 64'(1000 + k));
        start = 1'b1;
        @(negedge clk);
        check_vec("ign_addr", bus.w_addr, 21);
        check_vec("ign_busy", busy, 1);
        @(negedge clk);
        start = 1'b0;
        for (int k = 21; k <= 39; k++) next_result(k, 64'(1000 + k));
        @(negedge clk);
        check_vec("ab_fetch", bus.w_rd_en, 1);
        check_vec("ab_addr", bus.w_addr, 40);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset("post_abort");

        // Full pass after abort; start on the final handshake is ignored,
        // start in the done cycle is accepted.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k <= 83; k++) next_result(k, 64'(1000 + k));
        start = 1'b1;
        @(negedge clk);
        check_vec("fin_done", done, 1);
        check_vec("fin_busy", busy, 0);
        check_vec("fin_rd_en", bus.w_rd_en, 0);
        @(negedge clk);
        start = 1'b0;
        check_vec("done_start_rd_en", bus.w_rd_en, 1);
        check_vec("done_start_addr", bus.w_addr, 0);
        check_vec("done_start_busy", busy, 1);
        check_vec("done_once", done, 0);

        // ReLU behaviour on the pass just started.
        ovr_en  = 1'b1;
        ovr_val = 64'hFFFF_FFFF_FFFF_FFFB;
        next_result(0, relu_neg);
        ovr_val = 64'd7;
        next_result(1, 64'd7);
        ovr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // RD_LAT=3 instance: only the sample in cycle F+3 may be captured.
        @(negedge clk);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        check_vec("l3_fetch0", bus3.w_rd_en, 1);
        check_vec("l3_addr0", bus3.w_addr, 0);
        @(negedge clk);
        check_vec("l3_rd_en_f1", bus3.w_rd_en, 0);
        @(negedge clk);
        @(negedge clk);
        fc3 = 64'd42;
        check_vec("l3_valid_f3", bus3.res_valid, 0);
        @(negedge clk);
        fc3 = 64'hDEAD;
        check_vec("l3_valid_f4", bus3.res_valid, 1);
        check_vec("l3_data0", bus3.res_data, 42);
        check_vec("l3_idx0", bus3.res_idx, 0);
        @(negedge clk);
        check_vec("l3_fetch1", bus3.w_rd_en, 1);
        check_vec("l3_addr1", bus3.w_addr, 1);
        for (int i = 0; i < 3; i++) @(negedge clk);
        check_vec("l3_valid_f8", bus3.res_valid, 0);
        @(negedge clk);
        check_vec("l3_valid_f9", bus3.res_valid, 1);
        check_vec("l3_data1", bus3.res_data, 64'hDEAD);
        check_vec("l3_idx1", bus3.res_idx, 1);
        @(negedge clk);
        check_vec("l3_done", done3, 1);
        check_vec("l3_busy", busy3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
